// File: rtl/secure_boot_sequencer_if.sv
// Image-memory read channel between the boot sequencer (master) and memory (slave).
interface secure_boot_sequencer_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/secure_boot_sequencer.sv
// Secure boot sequencer: digests the primary image slot, falls back to the backup
// slot on mismatch or memory timeout, and reports sticky boot_ok / boot_fail.
module secure_boot_sequencer #(
  parameter int unsigned    DW           = 32,
  parameter int unsigned    AW           = 16,
  parameter int unsigned    IMG_WORDS    = 256,
  parameter logic [AW-1:0]  PRIMARY_BASE = 16'h0000,
  parameter logic [AW-1:0]  BACKUP_BASE  = 16'h1000,
  parameter logic [DW-1:0]  DIGEST_INIT  = '0,
  parameter int unsigned    ACK_TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     power_on,
  secure_boot_sequencer_if.master  mem,
  input  logic [DW-1:0]            golden_primary,
  input  logic [DW-1:0]            golden_backup,
  output logic                     busy,
  output logic                     boot_ok,
  output logic                     boot_fail,
  output logic                     boot_slot
);

  localparam int unsigned IW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LastIdx  = IW'(IMG_WORDS - 1);
  localparam logic [TW-1:0] LastTout = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StCheck, StPass, StFail} state_e;

  state_e        state_q, state_d;
  logic          slot_q, slot_d;
  logic [DW-1:0] digest_q, digest_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          slot_fail;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      slot_q   <= 1'b0;
      digest_q <= DIGEST_INIT;
      idx_q    <= '0;
      tout_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      digest_q <= digest_d;
      idx_q    <= idx_d;
      tout_q   <= tout_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic: fetch/digest loop, compare, slot fallback and power_on abort.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    digest_d  = digest_q;
    idx_d     = idx_q;
    tout_d    = tout_q;
    addr_d    = addr_q;
    slot_fail = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (power_on) begin
          state_d  = StFetch;
          slot_d   = 1'b0;
          digest_d = DIGEST_INIT;
          idx_d    = '0;
          tout_d   = '0;
          addr_d   = PRIMARY_BASE;
        end
      end
      StFetch: begin
        if (power_on) begin
          if (mem.mem_ack) begin
            digest_d = {digest_q[DW-2:0], digest_q[DW-1]} ^ mem.mem_rdata;
            tout_d   = '0;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_d = StCheck;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else if (tout_q == LastTout) begin
            // Memory never answered: give up on this slot without a compare.
            slot_fail = 1'b1;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (power_on) begin
          if (digest_q == (slot_q ? golden_backup : golden_primary)) begin
            state_d = StPass;
          end else begin
            slot_fail = 1'b1;
          end
        end
      end
      StPass, StFail: ;
      default: state_d = StIdle;
    endcase

    if (slot_fail) begin
      if (!slot_q) begin
        state_d  = StFetch;
        slot_d   = 1'b1;
        digest_d = DIGEST_INIT;
        idx_d    = '0;
        tout_d   = '0;
        addr_d   = BACKUP_BASE;
      end else begin
        state_d = StFail;
      end
    end

    // Dropping power_on abandons any boot in progress, including a same-cycle ack.
    if (!power_on && state_q != StIdle) begin
      state_d  = StIdle;
      slot_d   = 1'b0;
      digest_d = DIGEST_INIT;
      idx_d    = '0;
      tout_d   = '0;
      addr_d   = '0;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    mem.mem_req  = (state_q == StFetch);
    mem.mem_addr = addr_q;
    busy         = (state_q == StFetch) || (state_q == StCheck);
    boot_ok      = (state_q == StPass);
    boot_fail    = (state_q == StFail);
    boot_slot    = (state_q != StIdle) && slot_q;
  end

endmodule

// File: tb/tb_secure_boot_sequencer.sv
// Directed bench for secure_boot_sequencer with a 2-word image.
module tb_secure_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        power_on;
  logic        ack;
  logic [31:0] golden_primary, golden_backup;
  logic [31:0] p0, p1, b0, b1;
  logic        busy, boot_ok, boot_fail, boot_slot;

  int n_total = 0;
  int n_bad   = 0;

  secure_boot_sequencer_if #(.DW(32), .AW(16)) mem_if ();

  secure_boot_sequencer #(
    .DW(32), .AW(16), .IMG_WORDS(2), .PRIMARY_BASE(16'h0000), .BACKUP_BASE(16'h1000),
    .DIGEST_INIT(32'h0), .ACK_TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .power_on       (power_on),
    .mem            (mem_if.master),
    .golden_primary (golden_primary),
    .golden_backup  (golden_backup),
    .busy           (busy),
    .boot_ok        (boot_ok),
    .boot_fail      (boot_fail),
    .boot_slot      (boot_slot)
  );

  always #5 clk = ~clk;

  // Image memory model: two words per slot.
  always_comb begin
    mem_if.mem_ack = ack;
    if (mem_if.mem_addr == 16'h0000)      mem_if.mem_rdata = p0;
    else if (mem_if.mem_addr == 16'h0001) mem_if.mem_rdata = p1;
    else if (mem_if.mem_addr == 16'h1000) mem_if.mem_rdata = b0;
    else if (mem_if.mem_addr == 16'h1001) mem_if.mem_rdata = b1;
    else                                  mem_if.mem_rdata = 32'hdead_beef;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},  32'(mem_if.mem_req), 32'd0);
    check({tag, ".addr"}, 32'(mem_if.mem_addr), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".ok"},   32'(boot_ok), 32'd0);
    check({tag, ".fail"}, 32'(boot_fail), 32'd0);
    check({tag, ".slot"}, 32'(boot_slot), 32'd0);
  endtask

  task automatic go_idle();
    power_on = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; power_on = 1'b0; ack = 1'b0;
    golden_primary = 32'd0; golden_backup = 32'd0;
    p0 = 32'd1; p1 = 32'd2; b0 = 32'd3; b1 = 32'd6;
    #3;
    check_all_zero("reset");
    #20;
    @(negedge clk); rst_n = 1'b1;
    step();
    check_all_zero("idle_after_reset");

    // Primary pass: digest 1 then rotl1(1)^2 = 0; boot_ok after 4 edges.
    ack = 1'b1; golden_primary = 32'd0; golden_backup = 32'd9;
    power_on = 1'b1;
    step();
    check("pp.req1",  32'(mem_if.mem_req), 32'd1);
    check("pp.addr1", 32'(mem_if.mem_addr), 32'h0000);
    check("pp.busy1", 32'(busy), 32'd1);
    step(); step();
    check("pp.ok3", 32'(boot_ok), 32'd0);
    check("pp.req3", 32'(mem_if.mem_req), 32'd0);
    step();
    check("pp.ok4",   32'(boot_ok), 32'd1);
    check("pp.fail4", 32'(boot_fail), 32'd0);
    check("pp.slot4", 32'(boot_slot), 32'd0);
    check("pp.busy4", 32'(busy), 32'd0);
    go_idle();
    check_all_zero("pp_off");

    // Backup pass: primary digest 0 != 5; backup 3, 6^6 = 0 matches.
    golden_primary = 32'd5; golden_backup = 32'd0;
    power_on = 1'b1;
    step(); step(); step();
    check("bp.check_req", 32'(mem_if.mem_req), 32'd0);
    step();
    check("bp.addr4", 32'(mem_if.mem_addr), 32'h1000);
    check("bp.slot4", 32'(boot_slot), 32'd1);
    check("bp.req4",  32'(mem_if.mem_req), 32'd1);
    step();
    check("bp.addr5", 32'(mem_if.mem_addr), 32'h1001);
    step();
    check("bp.ok6", 32'(boot_ok), 32'd0);
    step();
    check("bp.ok7",   32'(boot_ok), 32'd1);
    check("bp.slot7", 32'(boot_slot), 32'd1);
    go_idle();

    // Both slots fail.
    golden_primary = 32'd5; golden_backup = 32'd7;
    power_on = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("ff.fail", 32'(boot_fail), 32'd1);
    check("ff.ok",   32'(boot_ok), 32'd0);
    check("ff.slot", 32'(boot_slot), 32'd1);
    check("ff.busy", 32'(busy), 32'd0);
    step(); step();
    check("ff.hold", 32'(boot_fail), 32'd1);
    go_idle();
    check_all_zero("ff_off");

    // Timeout after one accepted beat; backup must start from a fresh digest.
    golden_primary = 32'd0; golden_backup = 32'd0;
    ack = 1'b1; power_on = 1'b1;
    step(); step();
    ack = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("to.addr_stall", 32'(mem_if.mem_addr), 32'h0001);
    check("to.slot_stall", 32'(boot_slot), 32'd0);
    step();
    check("to.addr_bk", 32'(mem_if.mem_addr), 32'h1000);
    check("to.slot_bk", 32'(boot_slot), 32'd1);
    check("to.req_bk",  32'(mem_if.mem_req), 32'd1);
    ack = 1'b1;
    step(); step(); step();
    check("to.ok", 32'(boot_ok), 32'd1);
    go_idle();

    // Both slots time out.
    ack = 1'b0; power_on = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    check("to2.addr_bk", 32'(mem_if.mem_addr), 32'h1000);
    for (int i = 0; i < 14; i++) step();
    check("to2.busy", 32'(busy), 32'd1);
    step();
    check("to2.fail", 32'(boot_fail), 32'd1);
    go_idle();

    // Backpressure: ack 1,0,0,1; digest must still match golden 0.
    golden_primary = 32'd0; golden_backup = 32'd9;
    ack = 1'b0; power_on = 1'b1;
    step();
    ack = 1'b1; step();
    check("bk.addr_a", 32'(mem_if.mem_addr), 32'h0001);
    ack = 1'b0; step();
    check("bk.addr_s1", 32'(mem_if.mem_addr), 32'h0001);
    step();
    check("bk.addr_s2", 32'(mem_if.mem_addr), 32'h0001);
    check("bk.req_s2",  32'(mem_if.mem_req), 32'd1);
    ack = 1'b1; step();
    check("bk.req_chk", 32'(mem_if.mem_req), 32'd0);
    step();
    check("bk.ok",   32'(boot_ok), 32'd1);
    check("bk.slot", 32'(boot_slot), 32'd0);
    go_idle();

    // power_on abort mid-FETCH with a same-cycle ack.
    ack = 1'b0; power_on = 1'b1;
    step(); step();
    power_on = 1'b0; ack = 1'b1;
    step();
    check_all_zero("abort");
    power_on = 1'b1;
    step();
    check("abort.restart_addr", 32'(mem_if.mem_addr), 32'h0000);
    step(); step(); step();
    check("abort.restart_ok", 32'(boot_ok), 32'd1);
    go_idle();

    // Asynchronous reset mid-FETCH.
    ack = 1'b0; power_on = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk); rst_n = 1'b1; ack = 1'b1;
    step();
    check("rst.restart_req",  32'(mem_if.mem_req), 32'd1);
    check("rst.restart_addr", 32'(mem_if.mem_addr), 32'h0000);
    step(); step(); step();
    check("rst.restart_ok", 32'(boot_ok), 32'd1);
    go_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
